serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 133 +++++++++++++
 tb/tb_serial_adder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder
//   Digit-serial adder/subtractor. Operands are captured on an accepted start
//   and processed DIGIT bits per clock, least-significant slice first. The
//   result and flags are published on the edge that enters DONE. They then
//   hold until the next operation completes.
//
//   Ports
//     sys_clk    in   clock, rising edge
//     sys_rst_n  in   asynchronous active-low reset
//     start      in   begin an operation (only looked at in IDLE)
//     mode       in   0 = in1 + in2 + cin, 1 = in1 - in2
//     in1, in2   in   operands, WIDTH bits
//     cin        in   carry-in for add (ignored for subtract)
//     busy       out  high in RUN and DONE
//     done       out  one-cycle pulse, high during DONE
//     sum        out  WIDTH-bit result
//     carry      out  carry out of MSB (subtract: 1 = no borrow)
//     overflow   out  signed two's-complement overflow
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; outputs hold the last result
//   RUN   | one DIGIT-wide slice added per cycle, LSB slice first
//   DONE  | result valid, done pulse; returns to IDLE after one cycle
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CW     = $clog2(NSLICE) + 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cy;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] work;

    logic [DIGIT:0]   slice_sum;
    logic             slice_cout;
    logic             msb_cin;
    logic [WIDTH-1:0] next_work;
    int               slice_lo;

    always_comb begin
        slice_sum  = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, cy};
        slice_cout = slice_sum[DIGIT];
        // The carry into the top bit of a slice can be recovered from that
        // bit's sum and inputs. This avoids a special case when DIGIT is 1.
        msb_cin    = op_a[DIGIT-1] ^ op_b[DIGIT-1] ^ slice_sum[DIGIT-1];
        slice_lo   = int'(cnt) * DIGIT;
        next_work  = work;
        next_work[slice_lo +: DIGIT] = slice_sum[DIGIT-1:0];
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            cy       <= 1'b0;
            cnt      <= '0;
            work     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a  <= in1;
                        op_b  <= mode ? ~in2 : in2;
                        cy    <= mode ? 1'b1 : cin;
                        cnt   <= '0;
                        work  <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    work <= next_work;
                    cy   <= slice_cout;
                    op_a <= op_a >> DIGIT;
                    op_b <= op_b >> DIGIT;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST_SLICE) begin
                        sum      <= next_work;
                        carry    <= slice_cout;
                        overflow <= msb_cin ^ slice_cout;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder. Three instances (DIGIT = 1, 4, 8; WIDTH = 8) share
// the same inputs, so each vector is checked at all three digit widths.
module tb_serial_adder;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       start;
    logic       mode;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       cin;

    logic       busy_v     [3];
    logic       done_v     [3];
    logic [7:0] sum_v      [3];
    logic       carry_v    [3];
    logic       overflow_v [3];

    int n_checks = 0;
    int n_pass   = 0;

    // Cycles from the accepting edge to DONE entry, counting the accepting edge.
    int exp_lat [3] = '{9, 3, 2};

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .mode(mode),
        .in1(in1), .in2(in2), .cin(cin), .busy(busy_v[0]), .done(done_v[0]),
        .sum(sum_v[0]), .carry(carry_v[0]), .overflow(overflow_v[0]));

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .mode(mode),
        .in1(in1), .in2(in2), .cin(cin), .busy(busy_v[1]), .done(done_v[1]),
        .sum(sum_v[1]), .carry(carry_v[1]), .overflow(overflow_v[1]));

    serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .mode(mode),
        .in1(in1), .in2(in2), .cin(cin), .busy(busy_v[2]), .done(done_v[2]),
        .sum(sum_v[2]), .carry(carry_v[2]), .overflow(overflow_v[2]));

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Runs one operation on all instances. Inputs are scrambled while busy.
    // With pulse_busy set, start is also pulsed so that it is sampled at the
    // third edge, while every instance is still busy.
    task automatic do_op(input string tag, input logic m, input logic [7:0] a,
                         input logic [7:0] b, input logic c,
                         input logic [7:0] e_sum, input logic e_carry,
                         input logic e_ovf, input bit pulse_busy);
        int         lat     [3];
        int         pulses  [3];
        logic [7:0] got_sum [3];
        logic       got_cy  [3];
        logic       got_ov  [3];
        for (int k = 0; k < 3; k++) begin
            lat[k] = 0; pulses[k] = 0; got_sum[k] = 'x; got_cy[k] = 1'bx; got_ov[k] = 1'bx;
        end
        @(negedge sys_clk);
        start = 1'b1; mode = m; in1 = a; in2 = b; cin = c;
        @(posedge sys_clk);
        #1;
        start = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            in1  = 8'($urandom);
            in2  = 8'($urandom);
            mode = 1'($urandom);
            cin  = 1'($urandom);
            start = (pulse_busy && e == 2);
            @(negedge sys_clk);
            for (int k = 0; k < 3; k++) begin
                if (done_v[k] === 1'b1) begin
                    pulses[k]++;
                    if (lat[k] == 0) begin
                        lat[k]     = e;
                        got_sum[k] = sum_v[k];
                        got_cy[k]  = carry_v[k];
                        got_ov[k]  = overflow_v[k];
                    end
                end
            end
            @(posedge sys_clk);
            #1;
        end
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s d%0d sum", tag, k), 32'(got_sum[k]), 32'(e_sum));
            check($sformatf("%s d%0d carry", tag, k), 32'(got_cy[k]), 32'(e_carry));
            check($sformatf("%s d%0d ovf", tag, k), 32'(got_ov[k]), 32'(e_ovf));
            check($sformatf("%s d%0d latency", tag, k), 32'(lat[k]), 32'(exp_lat[k]));
            check($sformatf("%s d%0d pulses", tag, k), 32'(pulses[k]), 32'd1);
            check($sformatf("%s d%0d hold", tag, k), 32'(sum_v[k]), 32'(e_sum));
        end
    endtask

    initial begin
        logic [7:0] ra, rb, rbb, rs;
        logic       rm, rc, rco, rov;
        logic [8:0] t;

        start = 1'b0; mode = 1'b0; in1 = '0; in2 = '0; cin = 1'b0;
        sys_rst_n = 1'b0;
        #3;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst d%0d busy", k), 32'(busy_v[k]), 32'd0);
            check($sformatf("rst d%0d done", k), 32'(done_v[k]), 32'd0);
            check($sformatf("rst d%0d sum", k), 32'(sum_v[k]), 32'd0);
            check($sformatf("rst d%0d carry", k), 32'(carry_v[k]), 32'd0);
            check($sformatf("rst d%0d ovf", k), 32'(overflow_v[k]), 32'd0);
        end
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        do_op("ff+01",   1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        do_op("7f+01+1", 1'b0, 8'h7F, 8'h01, 1'b1, 8'h81, 1'b0, 1'b1, 1'b0);
        do_op("05-07",   1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        do_op("80-01",   1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0);
        do_op("55-55",   1'b1, 8'h55, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        do_op("80+80",   1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        do_op("ignstart",1'b0, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of an operation.
        @(negedge sys_clk);
        start = 1'b1; mode = 1'b0; in1 = 8'hAA; in2 = 8'h11; cin = 1'b0;
        @(posedge sys_clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("midrst d%0d busy", k), 32'(busy_v[k]), 32'd0);
            check($sformatf("midrst d%0d done", k), 32'(done_v[k]), 32'd0);
            check($sformatf("midrst d%0d sum", k), 32'(sum_v[k]), 32'd0);
        end
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            check("midrst d1 no done", 32'(done_v[0]), 32'd0);
        end
        do_op("10+20",   1'b0, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rm = 1'($urandom);
            rc = 1'($urandom);
            rbb = rm ? ~rb : rb;
            t   = {1'b0, ra} + {1'b0, rbb} + {8'd0, (rm ? 1'b1 : rc)};
            rs  = t[7:0];
            rco = t[8];
            rov = (ra[7] == rbb[7]) && (rs[7] != ra[7]);
            do_op($sformatf("rnd%0d", i), rm, ra, rb, rc, rs, rco, rov, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
